// File: rtl/ramio_arbiter.sv
// N-channel arbiter sharing one ramio instance among hold-until-done requesters.
// Define RAMIO_ARBITER_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module ramio_arbiter #(
  parameter int NumPorts        = 2,
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NumPorts-1:0]                   req,
  input  logic [NumPorts*3-1:0]                 req_read_type,
  input  logic [NumPorts*2-1:0]                 req_write_type,
  input  logic [NumPorts*AddressBitWidth-1:0]   req_address,
  input  logic [NumPorts*DataBitWidth-1:0]      req_data_in,
  output logic [NumPorts-1:0]                   done,
  output logic [DataBitWidth-1:0]               rd_data,
  output logic [NumPorts-1:0]                   grant,
  output logic                                  ramio_enable,
  output logic [2:0]                            ramio_read_type,
  output logic [1:0]                            ramio_write_type,
  output logic [AddressBitWidth-1:0]            ramio_address,
  output logic [DataBitWidth-1:0]               ramio_data_in,
  input  logic [DataBitWidth-1:0]               ramio_data_out,
  input  logic                                  ramio_data_out_ready,
  input  logic                                  ramio_busy
);

  localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT1 = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t                       state_r;
  logic [IdxW-1:0]              owner_r;
  logic                         is_read_r;
  logic [NumPorts-1:0]          grant_r;
  logic [NumPorts-1:0]          done_r;
  logic [DataBitWidth-1:0]      rd_data_r;
  logic                         en_r;
  logic [2:0]                   rt_r;
  logic [1:0]                   wt_r;
  logic [AddressBitWidth-1:0]   addr_r;
  logic [DataBitWidth-1:0]      wdata_r;

  logic [IdxW-1:0]              base_s;
  logic [2*NumPorts-1:0]        req_dbl_s;
  logic [2*NumPorts-1:0]        rot_s;
  logic                         sel_valid_s;
  logic [IdxW:0]                sel_off_s;
  logic [IdxW:0]                sel_sum_s;
  logic [IdxW-1:0]              sel_idx_s;
  logic [2:0]                   sel_rt_s;
  logic [1:0]                   sel_wt_s;
  logic [AddressBitWidth-1:0]   sel_addr_s;
  logic [DataBitWidth-1:0]      sel_data_s;
  logic                         sel_null_s;
  logic                         sel_read_s;
  logic                         complete_s;

  function automatic logic [NumPorts-1:0] to_onehot(input logic [IdxW-1:0] idx);
    logic [NumPorts-1:0] oh;
    oh = '0;
    for (int i = 0; i < NumPorts; i++) begin
      oh[i] = (idx == IdxW'(i));
    end
    return oh;
  endfunction

  // Priority search: first requester at or after base_s, modulo NumPorts.
  always_comb begin
    req_dbl_s   = {req, req};
    rot_s       = req_dbl_s >> base_s;
    sel_valid_s = 1'b0;
    sel_off_s   = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      sel_valid_s = sel_valid_s | rot_s[i];
      sel_off_s   = rot_s[i] ? (IdxW+1)'(i) : sel_off_s;
    end
    sel_sum_s = {1'b0, base_s} + sel_off_s;
    if (sel_sum_s >= (IdxW+1)'(NumPorts)) begin
      sel_idx_s = IdxW'(sel_sum_s - (IdxW+1)'(NumPorts));
    end else begin
      sel_idx_s = IdxW'(sel_sum_s);
    end
  end

  // Field mux for the selected channel and request classification.
  always_comb begin
    sel_rt_s   = 3'b000;
    sel_wt_s   = 2'b00;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NumPorts; i++) begin
      sel_rt_s   = (sel_idx_s == IdxW'(i)) ? req_read_type[3*i +: 3] : sel_rt_s;
      sel_wt_s   = (sel_idx_s == IdxW'(i)) ? req_write_type[2*i +: 2] : sel_wt_s;
      sel_addr_s = (sel_idx_s == IdxW'(i)) ? req_address[AddressBitWidth*i +: AddressBitWidth] : sel_addr_s;
      sel_data_s = (sel_idx_s == IdxW'(i)) ? req_data_in[DataBitWidth*i +: DataBitWidth] : sel_data_s;
    end
    sel_null_s = (sel_rt_s == 3'b000) && (sel_wt_s == 2'b00);
    sel_read_s = (sel_rt_s != 3'b000) && (sel_wt_s == 2'b00);
    complete_s = (ramio_busy == 1'b0) && (!is_read_r || ramio_data_out_ready);
  end

`ifdef RAMIO_ARBITER_FIXED_PRIORITY_EN
  assign base_s = '0;
`else
  logic [IdxW-1:0] ptr_r;
  logic            ptr_load_s;
  logic [IdxW-1:0] ptr_next_s;

  function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] idx);
    logic [IdxW-1:0] nxt;
    if (idx == IdxW'(NumPorts - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + IdxW'(1);
    end
    return nxt;
  endfunction

  // Pointer moves past a channel once its null request or transaction completes.
  always_comb begin
    ptr_load_s = 1'b0;
    ptr_next_s = ptr_r;
    if ((state_r == ST_IDLE) && (done_r == '0) && sel_valid_s && sel_null_s) begin
      ptr_load_s = 1'b1;
      ptr_next_s = wrap_inc(sel_idx_s);
    end else if ((state_r == ST_WAIT) && complete_s) begin
      ptr_load_s = 1'b1;
      ptr_next_s = wrap_inc(owner_r);
    end else begin
      ptr_load_s = 1'b0;
      ptr_next_s = ptr_r;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (ptr_load_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign base_s = ptr_r;
`endif

  // Main sequencer: arbitration, single-cycle ramio enable, completion and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      owner_r   <= '0;
      is_read_r <= 1'b0;
      grant_r   <= '0;
      done_r    <= '0;
      rd_data_r <= '0;
      en_r      <= 1'b0;
      rt_r      <= 3'b000;
      wt_r      <= 2'b00;
      addr_r    <= '0;
      wdata_r   <= '0;
    end else begin
      done_r <= '0;
      case (state_r)
        ST_IDLE: begin
          en_r <= 1'b0;
          rt_r <= 3'b000;
          wt_r <= 2'b00;
          // Skip the done cycle: the finished requester is still holding req then.
          if (sel_valid_s && (done_r == '0)) begin
            if (sel_null_s) begin
              done_r <= to_onehot(sel_idx_s);
            end else begin
              grant_r   <= to_onehot(sel_idx_s);
              owner_r   <= sel_idx_s;
              is_read_r <= sel_read_s;
              rt_r      <= sel_read_s ? sel_rt_s : 3'b000;
              wt_r      <= sel_wt_s;
              addr_r    <= sel_addr_s;
              wdata_r   <= sel_data_s;
              state_r   <= ST_ISSUE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (!ramio_busy) begin
            en_r    <= 1'b1;
            state_r <= ST_WAIT1;
          end else begin
            en_r    <= 1'b0;
            state_r <= ST_ISSUE;
          end
        end
        ST_WAIT1: begin
          en_r    <= 1'b0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          en_r <= 1'b0;
          if (complete_s) begin
            if (is_read_r) begin
              rd_data_r <= ramio_data_out;
            end else begin
              rd_data_r <= rd_data_r;
            end
            done_r  <= grant_r;
            grant_r <= '0;
            rt_r    <= 3'b000;
            wt_r    <= 2'b00;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          en_r    <= 1'b0;
          grant_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign done             = done_r;
  assign rd_data          = rd_data_r;
  assign grant            = grant_r;
  assign ramio_enable     = en_r;
  assign ramio_read_type  = rt_r;
  assign ramio_write_type = wt_r;
  assign ramio_address    = addr_r;
  assign ramio_data_in    = wdata_r;

endmodule

// File: tb/tb_ramio_arbiter.sv
// Scoreboard bench for ramio_arbiter (4 channels) with a small behavioural ramio model.
module tb_ramio_arbiter;

  localparam int NP = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NP-1:0]  req = '0;
  logic [NP*3-1:0]  req_read_type = '0;
  logic [NP*2-1:0]  req_write_type = '0;
  logic [NP*32-1:0] req_address = '0;
  logic [NP*32-1:0] req_data_in = '0;
  logic [NP-1:0]  done;
  logic [31:0]    rd_data;
  logic [NP-1:0]  grant;
  logic           ramio_enable;
  logic [2:0]     ramio_read_type;
  logic [1:0]     ramio_write_type;
  logic [31:0]    ramio_address;
  logic [31:0]    ramio_data_in;
  logic [31:0]    m_dout = '0;
  logic           m_ready = 1'b0;
  logic           m_busy = 1'b0;
  logic           m_isread = 1'b0;
  int             m_cnt = 0;
  logic           ext_busy = 1'b0;
  logic           ramio_busy_s;
  logic [31:0]    rd_value = '0;
  int             latency = 3;

  int vec_count = 0;
  int err_count = 0;
  int en_count = 0;
  logic [31:0] cap_addr = '0, cap_data = '0;
  logic [2:0]  cap_rt = '0;
  logic [1:0]  cap_wt = '0;
  logic [NP-1:0] prev_grant = '0;
  logic [31:0] exp_rd = '0;

  typedef struct { int ch; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  int   grant_q[$];
  exp_t mon_e;
  int   mon_g;

  ramio_arbiter #(.NumPorts(NP), .AddressBitWidth(32), .DataBitWidth(32)) dut (
    .clk(clk), .rst(rst), .req(req), .req_read_type(req_read_type),
    .req_write_type(req_write_type), .req_address(req_address), .req_data_in(req_data_in),
    .done(done), .rd_data(rd_data), .grant(grant), .ramio_enable(ramio_enable),
    .ramio_read_type(ramio_read_type), .ramio_write_type(ramio_write_type),
    .ramio_address(ramio_address), .ramio_data_in(ramio_data_in),
    .ramio_data_out(m_dout), .ramio_data_out_ready(m_ready), .ramio_busy(ramio_busy_s)
  );

  always #5 clk = ~clk;
  assign ramio_busy_s = m_busy | ext_busy;

  function automatic logic [NP-1:0] oh4(input int ch);
    logic [NP-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[i] = (i == ch);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vec_count++;
    if (act !== expv) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail_event(input string name);
    vec_count++;
    err_count++;
    $display("FAIL %s", name);
  endtask

  // ramio model: busy for `latency` cycles after an enable, ready pulse on read completion
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_ready <= 1'b0; m_cnt <= 0;
    end else begin
      m_ready <= 1'b0;
      if (ramio_enable && !m_busy) begin
        m_busy   <= 1'b1;
        m_cnt    <= latency;
        m_isread <= (ramio_read_type != 3'b000) && (ramio_write_type == 2'b00);
      end else if (m_busy) begin
        if (m_cnt > 1) m_cnt <= m_cnt - 1;
        else begin
          m_busy <= 1'b0;
          if (m_isread) begin m_ready <= 1'b1; m_dout <= rd_value; end
        end
      end
    end
  end

  always @(posedge clk) if (ramio_enable) en_count <= en_count + 1;

  always @(negedge clk) begin
    if (ramio_enable) begin
      cap_addr <= ramio_address; cap_data <= ramio_data_in;
      cap_rt <= ramio_read_type; cap_wt <= ramio_write_type;
    end
  end

  // done monitor
  always @(negedge clk) begin
    if (done != '0) begin
      if (exp_q.size() == 0) fail_event("done_unexpected");
      else begin
        mon_e = exp_q.pop_front();
        check("done_onehot", 64'(done), 64'(oh4(mon_e.ch)));
        check("rd_data", 64'(rd_data), 64'(mon_e.data));
      end
    end
  end

  // grant monitor
  always @(negedge clk) begin
    if (grant != '0 && prev_grant == '0) begin
      if (grant_q.size() == 0) fail_event("grant_unexpected");
      else begin
        mon_g = grant_q.pop_front();
        check("grant_owner", 64'(grant), 64'(oh4(mon_g)));
      end
    end
    prev_grant <= grant;
  end

  task automatic set_fields(input int ch, input logic [2:0] rt, input logic [1:0] wt,
                            input logic [31:0] addr, input logic [31:0] wdata);
    req_read_type[3*ch +: 3]  = rt;
    req_write_type[2*ch +: 2] = wt;
    req_address[32*ch +: 32]  = addr;
    req_data_in[32*ch +: 32]  = wdata;
  endtask

  task automatic push_txn(input int ch, input logic [2:0] rt, input logic [1:0] wt);
    if (rt != 3'b000 && wt == 2'b00) exp_rd = rd_value;
    if (rt != 3'b000 || wt != 2'b00) grant_q.push_back(ch);
    exp_q.push_back('{ch: ch, data: exp_rd});
  endtask

  task automatic run_txn(input int ch, input logic [2:0] rt, input logic [1:0] wt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int en_cnt, output int lat_done, output int busy_gap,
                         output int grant_at);
    int start_en, fall_at;
    logic prev_b;
    @(negedge clk);
    set_fields(ch, rt, wt, addr, wdata);
    push_txn(ch, rt, wt);
    start_en = en_count; fall_at = -100; lat_done = -1; grant_at = -1;
    prev_b = ramio_busy_s;
    req[ch] = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (grant_at < 0 && grant != '0) grant_at = c;
      if (prev_b && !ramio_busy_s) fall_at = c;
      prev_b = ramio_busy_s;
      if (done[ch]) begin lat_done = c; break; end
    end
    req[ch] = 1'b0;
    if (lat_done < 0) fail_event("done_timeout");
    en_cnt = en_count - start_en;
    busy_gap = lat_done - fall_at;
  endtask

  task automatic run_multi(input logic [NP-1:0] mask, input int n, input bit hold);
    int got;
    got = 0;
    @(negedge clk);
    req = req | mask;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      if (done != '0) begin
        got++;
        if (!hold) req = req & ~done;
      end
    end
    req = req & ~mask;
    if (got < n) fail_event("multi_timeout");
  endtask

  initial begin
    int en, lat, gap, gat;
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int en, lat, gap, gat, order[8];
    repeat (3) @(negedge clk);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_rd_data", 64'(rd_data), 64'h0);
    check("rst_enable", 64'(ramio_enable), 64'h0);
    check("rst_types", 64'({ramio_read_type, ramio_write_type}), 64'h0);
    check("rst_addr_data", 64'({ramio_address, ramio_data_in}), 64'h0);
    rst = 1'b0;

    // channel 0 write
    run_txn(0, 3'b000, 2'b11, 32'h100, 32'hDEADBEEF, en, lat, gap, gat);
    check("w0_req_to_grant", 64'(gat), 64'd1);
    check("w0_enable_cycles", 64'(en), 64'd1);
    check("w0_busy_to_done", 64'(gap), 64'd1);
    check("w0_addr", 64'(cap_addr), 64'h100);
    check("w0_data", 64'(cap_data), 64'hDEADBEEF);
    check("w0_wtype", 64'(cap_wt), 64'h3);

    // channel 1 read
    rd_value = 32'h12345678;
    run_txn(1, 3'b111, 2'b00, 32'h200, 32'h0, en, lat, gap, gat);
    check("r1_enable_cycles", 64'(en), 64'd1);
    check("r1_addr", 64'(cap_addr), 64'h200);
    check("r1_rtype", 64'(cap_rt), 64'h7);
    repeat (3) @(negedge clk);
    check("r1_rd_held", 64'(rd_data), 64'h12345678);

    // channel 2 null request
    run_txn(2, 3'b000, 2'b00, 32'h0, 32'h0, en, lat, gap, gat);
    check("null_latency", 64'(lat), 64'd1);
    check("null_no_enable", 64'(en), 64'd0);

    // channel 3 write with ramio busy at issue
    ext_busy = 1'b1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("enable_while_busy", 64'(ramio_enable), 64'h0);
        end
        ext_busy = 1'b0;
      end
    join_none
    run_txn(3, 3'b000, 2'b01, 32'h300, 32'h33, en, lat, gap, gat);
    check("busy_enable_cycles", 64'(en), 64'd1);

    // all four channels requesting for 8 transactions
    for (int i = 0; i < NP; i++) set_fields(i, 3'b000, 2'b10, 32'h400 + i, 32'h40 + i);
`ifdef RAMIO_ARBITER_FIXED_PRIORITY_EN
    order = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int i = 0; i < 8; i++) push_txn(order[i], 3'b000, 2'b10);
    en = en_count;
    run_multi(4'b1111, 8, 1'b1);
    check("all_enable_cycles", 64'(en_count - en), 64'd8);

    // both types nonzero: treated as write, rd_data untouched
    rd_value = 32'hCAFEF00D;
    run_txn(0, 3'b001, 2'b01, 32'h500, 32'h55, en, lat, gap, gat);
    check("both_enable_cycles", 64'(en), 64'd1);

    // channel 2 write moves the pointer to 3
    run_txn(2, 3'b000, 2'b01, 32'h600, 32'h66, en, lat, gap, gat);

    // reset in WAIT
    latency = 10;
    @(negedge clk);
    set_fields(2, 3'b000, 2'b01, 32'h700, 32'h77);
    grant_q.push_back(2);
    req[2] = 1'b1;
    for (int c = 0; c < 20 && !ramio_enable; c++) @(negedge clk);
    check("rstw_enable_seen", 64'(ramio_enable), 64'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_grant", 64'(grant), 64'h0);
    check("rstw_done", 64'(done), 64'h0);
    check("rstw_enable", 64'(ramio_enable), 64'h0);
    check("rstw_rd_data", 64'(rd_data), 64'h0);
    exp_rd = 32'h0;
    req[2] = 1'b0;
    rst = 1'b0;
    latency = 3;
    repeat (3) @(negedge clk);

    // channels 1 and 3 together: pointer back at 0 means 1 first
    set_fields(1, 3'b000, 2'b01, 32'h800, 32'h88);
    set_fields(3, 3'b000, 2'b01, 32'h900, 32'h99);
    push_txn(1, 3'b000, 2'b01);
    push_txn(3, 3'b000, 2'b01);
    run_multi(4'b1010, 2, 1'b0);

    repeat (4) @(negedge clk);
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("grant_queue_drained", 64'(grant_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/ramio_arbiter.md
Name: ramio_arbiter

Overview:
- N-channel round-robin arbiter. Lets several masters (core fetch/data port, DMA, debug) share one ramio instance.
- Sits between requesters and ramio. Presents one ramio-side master interface: enable, read_type, write_type, address, data_in, data_out, data_out_ready, busy.
- Each channel uses a hold-until-done request handshake. The arbiter registers the owning channel and read data, and returns a one-cycle done pulse.

Parameters:
NumPorts, 2, number of requester channels (2..8)
AddressBitWidth, 32, address width per channel and on ramio side
DataBitWidth, 32, data width per channel and on ramio side

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  NumPorts  per-channel request; held high with its fields stable until that channel's done pulse
req_read_type  in  NumPorts*3  per-channel ramio read_type, channel i at [3i+2:3i]
req_write_type  in  NumPorts*2  per-channel ramio write_type, channel i at [2i+1:2i]
req_address  in  NumPorts*AddressBitWidth  per-channel address
req_data_in  in  NumPorts*DataBitWidth  per-channel write data
done  out  NumPorts  one-cycle pulse, channel i transaction complete
rd_data  out  DataBitWidth  registered read data, valid in the done cycle and held until the next done
grant  out  NumPorts  one-hot current owner, zero when idle
ramio_enable  out  1  to ramio
ramio_read_type  out  3  to ramio
ramio_write_type  out  2  to ramio
ramio_address  out  AddressBitWidth  to ramio
ramio_data_in  out  DataBitWidth  to ramio
ramio_data_out  in  DataBitWidth  from ramio
ramio_data_out_ready  in  1  from ramio
ramio_busy  in  1  from ramio

Behaviour:
- Reset: on rst sampled high:
  - state=IDLE
  - grant=0, done=0, rd_data=0
  - ramio_enable=0, ramio_read_type=0, ramio_write_type=0, ramio_address=0, ramio_data_in=0
  - round-robin pointer=0 (channel 0 has highest priority after reset)
- rst mid-transaction aborts arbiter state only. ramio is not signalled; ramio is reset from the same source in the top level.
- IDLE:
  - If any req is high, select the first requesting channel at or after pointer, modulo NumPorts.
  - Register grant and the selected channel's fields into the ramio_* field outputs. Go to ISSUE next cycle.
  - Request latency: req high in cycle N gives grant in N+1.
- Null request (read_type==0 and write_type==0):
  - Detected in IDLE. No ramio access.
  - done[i] pulses in N+1, grant stays 0, pointer advances.
- Both read_type and write_type nonzero: treated as a write. rd_data is not updated.
- ISSUE: ramio_enable=1 while ramio_busy==0. Exactly one enable-high cycle per transaction. Then go to WAIT1. If ramio_busy==1, hold in ISSUE with enable=0.
- WAIT1: one-cycle guard so ramio can raise busy. ramio_enable=0. Go to WAIT.
- WAIT completion condition:
  - write: ramio_busy==0
  - read: ramio_busy==0 and ramio_data_out_ready==1
- On completion:
  - For a read, rd_data <= ramio_data_out.
  - done[owner] pulses the next cycle.
  - grant <= 0.
  - pointer <= owner+1, wrapping to 0 after NumPorts-1.
  - state <= IDLE.
- ramio_read_type and ramio_write_type are driven to 0 in IDLE so ramio sees no stale type.
- Back-to-back: a channel still holding req after its done competes again. With all channels requesting, grants cycle 0,1,..,N-1,0.
- A req deasserted before done (protocol violation) does not abort the transaction; done still pulses.
- Fairness bound: a requesting channel waits at most NumPorts-1 transactions.

Optional Feature:
- Macro RAMIO_ARBITER_FIXED_PRIORITY_EN.
- Defined: pointer logic removed. The lowest-index requesting channel always wins, and channel 0 can starve others.
- Undefined (default): round-robin as above.

Test Plan:
- After reset, all outputs are 0. Channel 0 write at address 0x100, data 0xDEADBEEF, write_type=2'b11 -> ramio_enable high for exactly 1 cycle with those fields; done[0] pulses 1 cycle after ramio_busy falls.
- Channel 1 read at address 0x200, read_type=3'b111; model returns 0x12345678 with data_out_ready -> rd_data=0x12345678 in the done[1] cycle; rd_data is held afterwards.
- NumPorts=4, all req held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3. Under RAMIO_ARBITER_FIXED_PRIORITY_EN -> 0,0,0,...
- ramio_busy held high for 5 cycles at ISSUE -> ramio_enable stays 0 until busy drops, then exactly one enable cycle.
- Null request on channel 2 -> done[2] pulses in the cycle after req, with no ramio_enable.
- rst asserted in WAIT -> next cycle state IDLE, grant=0, no done pulse. A subsequent channel 1 request is served normally, and the pointer is back at 0.
